// File: rtl/inport_rr_scheduler_if.sv
// Bus bundle for the round-robin input scheduler: CPU read port plus the four
// requester valid/ack channels.
interface inport_rr_scheduler_if #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
);
    // Requester handshake: ReqAck[i] is a one-cycle pulse in the cycle where
    // ReqValid[i] is high and requester i wins arbitration. ReqDataN is captured
    // on that same edge. The requester may then drop valid or present its next
    // byte on the following cycle. Without an ack the byte must stay held.
    logic            INPortRead;
    logic [7:0]      Address;
    logic [3:0]      ReqValid;
    logic [7:0]      ReqData0;
    logic [7:0]      ReqData1;
    logic [7:0]      ReqData2;
    logic [7:0]      ReqData3;
    logic [3:0]      ReqAck;
    logic [7:0]      Dataout;
    logic [CNTW-1:0] Count;

    modport master (
        output INPortRead, Address, ReqValid, ReqData0, ReqData1, ReqData2, ReqData3,
        input  ReqAck, Dataout, Count
    );

    modport slave (
        input  INPortRead, Address, ReqValid, ReqData0, ReqData1, ReqData2, ReqData3,
        output ReqAck, Dataout, Count
    );
endinterface

// File: rtl/inport_rr_scheduler.sv
// Four-way round-robin scheduler that feeds tagged requester bytes into a shared
// FIFO, drained and inspected by the CPU through memory-mapped reads.
module inport_rr_scheduler #(
    parameter int         DEPTH     = 4,
    parameter int         CNTW      = 3,
    parameter logic [7:0] ADDR_STAT = 8'hF0,
    parameter logic [7:0] ADDR_DATA = 8'hF5,
    parameter logic [7:0] ADDR_SRC  = 8'hF6
) (
    input logic                  clk,
    input logic                  Reset,
    inport_rr_scheduler_if.slave bus
);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [9:0]      mem_q [DEPTH];
    logic [9:0]      mem_d [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic            ufl_q, ufl_d;
    logic [7:0]      dataout_q, dataout_d;

    logic       full, empty;
    logic       push, pop, ufl_set;
    logic [1:0] grant, idx;
    logic [7:0] req_data [4];
    logic [9:0] head;

    assign req_data[0] = bus.ReqData0;
    assign req_data[1] = bus.ReqData1;
    assign req_data[2] = bus.ReqData2;
    assign req_data[3] = bus.ReqData3;

    // Occupancy is judged at cycle start, so a same-cycle pop never frees a slot.
    assign full  = (count_q == CNTW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Search downward so the last match is the nearest requester from rr_ptr.
    always_comb begin
        push  = 1'b0;
        grant = rr_ptr_q;
        idx   = rr_ptr_q;
        if (!Reset && !full) begin
            for (int k = 3; k >= 0; k--) begin
                idx = rr_ptr_q + 2'(k);
                if (bus.ReqValid[idx]) begin
                    push  = 1'b1;
                    grant = idx;
                end
            end
        end
    end

    assign bus.ReqAck  = push ? (4'b0001 << grant) : 4'b0000;
    assign bus.Dataout = dataout_q;
    assign bus.Count   = count_q;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rr_ptr_d  = rr_ptr_q;
        ufl_d     = ufl_q;
        dataout_d = dataout_q;
        pop       = 1'b0;
        ufl_set   = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q] = {grant, req_data[grant]};
            wr_ptr_d        = wr_ptr_q + PTRW'(1);
            rr_ptr_d        = grant + 2'd1;
        end

        if (bus.INPortRead) begin
            case (bus.Address)
                ADDR_DATA: begin
                    if (!empty) begin
                        dataout_d = head[7:0];
                        pop       = 1'b1;
                        rd_ptr_d  = rd_ptr_q + PTRW'(1);
                    end else begin
                        dataout_d = 8'h00;
                        ufl_set   = 1'b1;
                    end
                end
                ADDR_SRC:  dataout_d = empty ? 8'h00 : {6'b0, head[9:8]};
                ADDR_STAT: begin
                    dataout_d = {full, empty, ufl_q, 1'b0, bus.ReqValid};
                    ufl_d     = 1'b0;
                end
                default:   dataout_d = 8'h00;
            endcase
        end

        // A fresh underflow outranks the read-to-clear of the status register.
        if (ufl_set) begin
            ufl_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rr_ptr_q  <= 2'd0;
            ufl_q     <= 1'b0;
            dataout_q <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rr_ptr_q  <= rr_ptr_d;
            ufl_q     <= ufl_d;
            dataout_q <= dataout_d;
        end
    end

    // Storage needs no reset; entries are only visible through valid pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_inport_rr_scheduler.sv
// Directed plus randomized bench for inport_rr_scheduler, checked against a
// queue-based reference model of the arbiter and FIFO.
module tb_inport_rr_scheduler;
    localparam int         DEPTH     = 4;
    localparam int         CNTW      = 3;
    localparam logic [7:0] ADDR_STAT = 8'hF0;
    localparam logic [7:0] ADDR_DATA = 8'hF5;
    localparam logic [7:0] ADDR_SRC  = 8'hF6;

    logic clk;
    logic Reset;

    inport_rr_scheduler_if #(.DEPTH(DEPTH), .CNTW(CNTW)) bus ();

    inport_rr_scheduler #(
        .DEPTH(DEPTH), .CNTW(CNTW),
        .ADDR_STAT(ADDR_STAT), .ADDR_DATA(ADDR_DATA), .ADDR_SRC(ADDR_SRC)
    ) dut (
        .clk  (clk),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO contents as {src, data}, round-robin start, sticky flag.
    logic [9:0] exp_q[$];
    int         rr;
    logic       ufl;
    logic [7:0] exp_dout;
    logic [3:0] last_ack;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] req_byte(input int i);
        case (i)
            0:       return bus.ReqData0;
            1:       return bus.ReqData1;
            2:       return bus.ReqData2;
            default: return bus.ReqData3;
        endcase
    endfunction

    // One clock: check ack mid-cycle, advance the model, check registered outputs.
    task automatic cycle();
        logic [3:0] eack;
        int         g;
        @(negedge clk);
        g    = -1;
        eack = 4'b0000;
        if (!Reset && exp_q.size() < DEPTH) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && bus.ReqValid[(rr + k) % 4]) g = (rr + k) % 4;
            end
        end
        if (g >= 0) eack[g] = 1'b1;
        last_ack = bus.ReqAck;
        check("ack", bus.ReqAck, eack);

        if (Reset) begin
            exp_q.delete();
            rr       = 0;
            ufl      = 1'b0;
            exp_dout = 8'h00;
        end else begin
            if (bus.INPortRead) begin
                if (bus.Address == ADDR_DATA) begin
                    if (exp_q.size() > 0) begin
                        exp_dout = exp_q[0][7:0];
                        void'(exp_q.pop_front());
                    end else begin
                        exp_dout = 8'h00;
                        ufl      = 1'b1;
                    end
                end else if (bus.Address == ADDR_SRC) begin
                    exp_dout = (exp_q.size() > 0) ? {6'b0, exp_q[0][9:8]} : 8'h00;
                end else if (bus.Address == ADDR_STAT) begin
                    exp_dout = {exp_q.size() == DEPTH, exp_q.size() == 0, ufl, 1'b0, bus.ReqValid};
                    ufl      = 1'b0;
                end else begin
                    exp_dout = 8'h00;
                end
            end
            if (g >= 0) begin
                exp_q.push_back({g[1:0], req_byte(g)});
                rr = (g + 1) % 4;
            end
        end

        @(posedge clk);
        #1;
        check("count", 32'(bus.Count), exp_q.size());
        check("dout", 32'(bus.Dataout), 32'(exp_dout));
    endtask

    task automatic rd(input logic [7:0] addr);
        bus.INPortRead = 1'b1;
        bus.Address    = addr;
        cycle();
        bus.INPortRead = 1'b0;
        bus.Address    = 8'h00;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
    endtask

    logic [7:0] addr_tbl [4];

    initial begin
        rr             = 0;
        ufl            = 1'b0;
        exp_dout       = 8'h00;
        last_ack       = 4'b0000;
        Reset          = 1'b1;
        bus.INPortRead = 1'b0;
        bus.Address    = 8'h00;
        bus.ReqValid   = 4'b0000;
        bus.ReqData0   = 8'h00;
        bus.ReqData1   = 8'h00;
        bus.ReqData2   = 8'h00;
        bus.ReqData3   = 8'h00;
        cycle();
        cycle();
        check("rst_count", 32'(bus.Count), 0);
        check("rst_dout", 32'(bus.Dataout), 0);
        Reset = 1'b0;

        // Single push from requester 0, then peek source and pop.
        bus.ReqValid = 4'b0001;
        bus.ReqData0 = 8'hA5;
        cycle();
        check("t1_ack", 32'(last_ack), 32'h1);
        check("t1_count", 32'(bus.Count), 1);
        bus.ReqValid = 4'b0000;
        rd(ADDR_SRC);
        check("t1_src", 32'(bus.Dataout), 32'h00);
        rd(ADDR_DATA);
        check("t1_data", 32'(bus.Dataout), 32'hA5);
        check("t1_empty", 32'(bus.Count), 0);

        // All four requesters valid from a fresh round-robin start.
        do_reset();
        bus.ReqValid = 4'b1111;
        bus.ReqData0 = 8'h10;
        bus.ReqData1 = 8'h11;
        bus.ReqData2 = 8'h12;
        bus.ReqData3 = 8'h13;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t2_order", 32'(last_ack), 32'(4'b0001 << i));
        end
        cycle();
        check("t2_full_noack", 32'(last_ack), 0);
        check("t2_count", 32'(bus.Count), 4);
        rd(ADDR_STAT);
        check("t2_stat", 32'(bus.Dataout), 32'h8F);

        // Pop on a full FIFO does not admit a push until the next cycle.
        bus.ReqValid = 4'b0001;
        rd(ADDR_DATA);
        check("t3_pop", 32'(bus.Dataout), 32'h10);
        check("t3_noack", 32'(last_ack), 0);
        check("t3_count3", 32'(bus.Count), 3);
        cycle();
        check("t3_ack", 32'(last_ack), 32'h1);
        check("t3_count4", 32'(bus.Count), 4);

        // Grant to requester 1 moves the pointer to 2; then 3, 0, 1.
        do_reset();
        bus.ReqValid = 4'b0010;
        cycle();
        bus.ReqValid = 4'b1011;
        cycle();
        check("t4_g3", 32'(last_ack), 32'h8);
        cycle();
        check("t4_g0", 32'(last_ack), 32'h1);
        cycle();
        check("t4_g1", 32'(last_ack), 32'h2);

        // Underflow flag sets, reads back once, then clears.
        do_reset();
        bus.ReqValid = 4'b0000;
        rd(ADDR_DATA);
        check("t5_ufl_data", 32'(bus.Dataout), 32'h00);
        rd(ADDR_STAT);
        check("t5_stat1", 32'(bus.Dataout), 32'h60);
        rd(ADDR_STAT);
        check("t5_stat2", 32'(bus.Dataout), 32'h40);

        // Underflowing pop and push together: push still lands.
        bus.ReqValid = 4'b0100;
        bus.ReqData2 = 8'h5C;
        rd(ADDR_DATA);
        check("t5b_count", 32'(bus.Count), 1);
        bus.ReqValid = 4'b0000;
        rd(ADDR_STAT);
        check("t5b_stat", 32'(bus.Dataout), 32'h20);

        // Reset mid-operation discards entries and suppresses ack.
        do_reset();
        bus.ReqValid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            bus.ReqData0 = 8'(8'h30 + i);
            cycle();
        end
        check("t6_count3", 32'(bus.Count), 3);
        Reset = 1'b1;
        cycle();
        check("t6_rst_noack", 32'(last_ack), 0);
        check("t6_rst_count", 32'(bus.Count), 0);
        check("t6_rst_dout", 32'(bus.Dataout), 0);
        Reset        = 1'b0;
        bus.ReqValid = 4'b1111;
        cycle();
        check("t6_resume", 32'(last_ack), 32'h1);

        // Randomized traffic against the model.
        addr_tbl[0] = ADDR_STAT;
        addr_tbl[1] = ADDR_DATA;
        addr_tbl[2] = ADDR_SRC;
        for (int n = 0; n < 600; n++) begin
            addr_tbl[3]    = 8'($urandom_range(0, 255));
            Reset          = ($urandom_range(0, 59) == 0);
            bus.ReqValid   = 4'($urandom_range(0, 15));
            bus.ReqData0   = 8'($urandom_range(0, 255));
            bus.ReqData1   = 8'($urandom_range(0, 255));
            bus.ReqData2   = 8'($urandom_range(0, 255));
            bus.ReqData3   = 8'($urandom_range(0, 255));
            bus.INPortRead = ($urandom_range(0, 1) == 1);
            bus.Address    = addr_tbl[$urandom_range(0, 3)];
            cycle();
        end
        Reset          = 1'b0;
        bus.INPortRead = 1'b0;
        bus.ReqValid   = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
